// File: rtl/nearest_decimator_pkg.sv
// Shared definitions for the nearest-neighbour decimator: default widths and
// the selection encoding between the bracketing input samples.
package nearest_decimator_pkg;

  localparam int unsigned DEF_INW     = 28;
  localparam int unsigned DEF_CTRBITS = 32;

  typedef enum logic {
    SEL_PREV    = 1'b0,
    SEL_CURRENT = 1'b1
  } sel_e;

endpackage

// File: rtl/nearest_decimator_if.sv
// Sample-stream bundle for the decimator: input strobe/step/data towards the
// block and output strobe/data back from it.
interface nearest_decimator_if #(
  parameter int unsigned INW     = 28,
  parameter int unsigned CTRBITS = 32
);

  logic               i_ce;
  logic [CTRBITS-1:0] i_step;
  logic [INW-1:0]     i_data;
  logic               o_ce;
  logic [INW-1:0]     o_data;

  modport master (
    output i_ce, i_step, i_data,
    input  o_ce, o_data
  );

  modport slave (
    input  i_ce, i_step, i_data,
    output o_ce, o_data
  );

endinterface

// File: rtl/nearest_decimator_nn_phase_acc.sv
// Phase accumulator for the decimator: flags an output instant on overflow and
// decides whether the current or the previous sample lies nearer to it.
module nn_phase_acc
  import nearest_decimator_pkg::*;
#(
  parameter int unsigned CTRBITS = DEF_CTRBITS
) (
  input  logic               i_clk,
  input  logic               i_reset_n,
  input  logic               i_ce,
  input  logic [CTRBITS-1:0] i_step,
  output logic               o_carry,
  output logic               o_sel_current
);

  logic [CTRBITS-1:0] r_counter;
  logic [CTRBITS:0]   sum_w;
  logic [CTRBITS:0]   twice_res;

  always_comb begin
    sum_w     = {1'b0, r_counter} + {1'b0, i_step};
    // Residue doubled at full width so the tie compare never truncates.
    twice_res = {sum_w[CTRBITS-1:0], 1'b0};
    o_carry       = i_ce & sum_w[CTRBITS];
    o_sel_current = (twice_res <= {1'b0, i_step});
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_counter <= '0;
    end else if (i_ce) begin
      r_counter <= sum_w[CTRBITS-1:0];
    end
  end

endmodule

// File: rtl/nearest_decimator.sv
// Nearest-neighbour rate reducer: emits, at each accumulator overflow, whichever
// bracketing input sample lies closer to the true output instant.
module nearest_decimator
  import nearest_decimator_pkg::*;
#(
  parameter int unsigned INW     = DEF_INW,
  parameter int unsigned CTRBITS = DEF_CTRBITS
) (
  input  logic                 i_clk,
  input  logic                 i_reset_n,
  nearest_decimator_if.slave   bus
);

  logic           carry;
  logic           sel_current;
  sel_e           sel;
  logic [INW-1:0] r_prev;
  logic [INW-1:0] pick;

  nn_phase_acc #(
    .CTRBITS (CTRBITS)
  ) u_phase_acc (
    .i_clk         (i_clk),
    .i_reset_n     (i_reset_n),
    .i_ce          (bus.i_ce),
    .i_step        (bus.i_step),
    .o_carry       (carry),
    .o_sel_current (sel_current)
  );

  always_comb begin
    sel  = sel_current ? SEL_CURRENT : SEL_PREV;
    pick = (sel == SEL_CURRENT) ? bus.i_data : r_prev;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      r_prev     <= '0;
      bus.o_ce   <= 1'b0;
      bus.o_data <= '0;
    end else begin
      bus.o_ce <= carry;
      if (carry) begin
        bus.o_data <= pick;
      end
      if (bus.i_ce) begin
        r_prev <= bus.i_data;
      end
    end
  end

endmodule

// File: tb/tb_nearest_decimator.sv
// Directed bench for nearest_decimator at 8-bit sample and accumulator widths.
module tb_nearest_decimator;

  localparam int unsigned W = 8;

  logic i_clk = 1'b0;
  logic i_reset_n = 1'b0;
  int   errors = 0;
  int   checks = 0;

  nearest_decimator_if #(.INW(W), .CTRBITS(W)) bus ();

  nearest_decimator #(
    .INW     (W),
    .CTRBITS (W)
  ) dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .bus       (bus)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic feed(input logic [W-1:0] d, input logic [W-1:0] s);
    @(negedge i_clk);
    bus.i_ce   = 1'b1;
    bus.i_data = d;
    bus.i_step = s;
    @(posedge i_clk);
    #1;
    bus.i_ce = 1'b0;
  endtask

  task automatic idle();
    @(negedge i_clk);
    bus.i_ce = 1'b0;
    @(posedge i_clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge i_clk);
    i_reset_n = 1'b0;
    #1;
    chk("rst_o_ce", {7'd0, bus.o_ce}, 8'h00);
    chk("rst_o_data", bus.o_data, 8'h00);
    @(negedge i_clk);
    i_reset_n = 1'b1;
  endtask

  initial begin : stim
    logic [W-1:0] ce_tab [10];
    logic [W-1:0] dat_tab[10];
    logic [W-1:0] c;
    logic [W-1:0] m_data;
    logic [W:0]   s9;
    int           pulses;

    bus.i_ce   = 1'b0;
    bus.i_data = '0;
    bus.i_step = '0;
    #12;
    chk("reset_o_ce", {7'd0, bus.o_ce}, 8'h00);
    chk("reset_o_data", bus.o_data, 8'h00);
    @(negedge i_clk);
    i_reset_n = 1'b1;

    // Decimate by 2
    ce_tab  = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    dat_tab = '{0, 2, 2, 4, 4, 6, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      feed(8'(i + 1), 8'h80);
      chk("div2_ce", {7'd0, bus.o_ce}, ce_tab[i]);
      chk("div2_data", bus.o_data, dat_tab[i]);
    end

    // Rate about 1/3: outputs select the previous sample
    do_reset();
    ce_tab  = '{0, 0, 0, 1, 0, 0, 1, 0, 0, 1};
    dat_tab = '{0, 0, 0, 3, 3, 3, 6, 6, 6, 9};
    for (int i = 0; i < 10; i++) begin
      feed(8'(i + 1), 8'h55);
      chk("third_ce", {7'd0, bus.o_ce}, ce_tab[i]);
      chk("third_data", bus.o_data, dat_tab[i]);
    end

    // Tie goes to the current sample
    do_reset();
    feed(8'd1, 8'hC0);
    chk("tie_ce0", {7'd0, bus.o_ce}, 8'h00);
    feed(8'd2, 8'h80);
    chk("tie_ce1", {7'd0, bus.o_ce}, 8'h01);
    chk("tie_data", bus.o_data, 8'h02);
    idle();
    chk("tie_ce_drop", {7'd0, bus.o_ce}, 8'h00);
    chk("tie_hold", bus.o_data, 8'h02);

    // Gapped strobes, 1-of-3
    do_reset();
    ce_tab  = '{0, 1, 0, 1, 0, 1, 0, 0, 0, 0};
    dat_tab = '{0, 2, 2, 4, 4, 6, 0, 0, 0, 0};
    for (int i = 0; i < 6; i++) begin
      feed(8'(i + 1), 8'h80);
      chk("gap_ce", {7'd0, bus.o_ce}, ce_tab[i]);
      chk("gap_data", bus.o_data, dat_tab[i]);
      for (int k = 0; k < 2; k++) begin
        idle();
        chk("gap_idle_ce", {7'd0, bus.o_ce}, 8'h00);
        chk("gap_idle_data", bus.o_data, dat_tab[i]);
      end
    end

    // Zero step never produces output
    do_reset();
    pulses = 0;
    for (int i = 0; i < 100; i++) begin
      feed(8'(i + 1), 8'h00);
      if (bus.o_ce === 1'b1) pulses++;
    end
    chk("zero_pulses", 8'(pulses), 8'h00);
    chk("zero_data", bus.o_data, 8'h00);

    // Reset mid-stream discards the counter
    do_reset();
    feed(8'd1, 8'h80);
    feed(8'd2, 8'h80);
    feed(8'd3, 8'h80);
    chk("mid_pre_data", bus.o_data, 8'h02);
    #2;
    i_reset_n = 1'b0;
    #1;
    chk("mid_rst_ce", {7'd0, bus.o_ce}, 8'h00);
    chk("mid_rst_data", bus.o_data, 8'h00);
    @(negedge i_clk);
    i_reset_n = 1'b1;
    feed(8'd10, 8'h80);
    chk("mid_first_ce", {7'd0, bus.o_ce}, 8'h00);
    chk("mid_first_data", bus.o_data, 8'h00);
    feed(8'd11, 8'h80);
    chk("mid_second_ce", {7'd0, bus.o_ce}, 8'h01);
    chk("mid_second_data", bus.o_data, 8'd11);

    // Max step against a reference of the accumulate/compare/select rule
    do_reset();
    c = '0;
    m_data = '0;
    pulses = 0;
    for (int n = 1; n <= 256; n++) begin
      s9 = {1'b0, c} + 9'h0FF;
      if (s9[8]) begin
        m_data = ({s9[7:0], 1'b0} <= 9'h0FF) ? 8'(n) : 8'(n - 1);
      end
      c = s9[7:0];
      feed(8'(n), 8'hFF);
      if (bus.o_ce === 1'b1) pulses++;
      chk("max_ce", {7'd0, bus.o_ce}, {7'd0, s9[8]});
      chk("max_data", bus.o_data, m_data);
    end
    checks++;
    assert (pulses == 255) else begin
      errors++;
      $error("FAIL max_pulses observed=%0d expected=255", pulses);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
